st_sp_sequencer: RTL

- Stack-pointer owner and sequencer for the Thumb stack-op unit; sits directly upstream and downstream of the combinational SP-arithmetic datapath.
- Holds the architectural SP register and drives the datapath's data_in/op_sel/immed7/immed8. Consumes the datapath's data_out.
- Expands multi-register PUSH/POP into one memory word transfer per listed register, using a request/ack memory handshake.

---
 rtl/st_sp_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/st_sp_sequencer.sv
// st_sp_sequencer: owns the architectural SP and sequences Thumb stack ops through the external SP datapath.
// EXEC ops retire 1 cycle after accept, PUSH/POP one register per acked access; define ST_STACK_LIMIT_EN for the stack-limit fault.
module st_sp_sequencer #(
  parameter logic [31:0] SP_RESET = 32'h0000_0400,
  parameter logic [31:0] SP_LIMIT = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  instr_op,
  input  logic [8:0]  instr_reglist,
  input  logic [6:0]  instr_immed7,
  input  logic [7:0]  instr_immed8,
  input  logic [31:0] reg_in,
  output logic [31:0] dp_data_in,
  output logic [7:0]  dp_op_sel,
  output logic [6:0]  dp_immed7,
  output logic [7:0]  dp_immed8,
  input  logic [31:0] dp_data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_reg_idx,
  input  logic        mem_ack,
  output logic [31:0] result,
  output logic        result_valid,
  output logic [31:0] sp,
  output logic        done,
  output logic        fault
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_PUSH = 3'd2;
  localparam logic [2:0] S_POP  = 3'd3;
  localparam logic [2:0] S_MEM1 = 3'd4;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_PUSH  = 8'h01;
  localparam logic [7:0] OP_POP   = 8'h02;
  localparam logic [7:0] OP_ADDSP = 8'h04;
  localparam logic [7:0] OP_SUBSP = 8'h08;
  localparam logic [7:0] OP_MOVSP = 8'h10;
  localparam logic [7:0] OP_ADDS  = 8'h20;
  localparam logic [7:0] OP_LDRSP = 8'h40;
  localparam logic [7:0] OP_STRSP = 8'h80;

  logic [2:0]  state;
  logic [31:0] sp_q;
  logic [31:0] result_q;
  logic        result_valid_q;
  logic [7:0]  op_q;
  logic [8:0]  list_q;
  logic [6:0]  imm7_q;
  logic [7:0]  imm8_q;

  logic [3:0]  push_idx;
  logic [3:0]  pop_idx;
  logic [3:0]  cur_idx;
  logic [8:0]  list_next;
  logic        step;
  logic        idle;
  logic        xfer;
  logic        limit_hit;
  logic        unused_sink;

  // PUSH stores from the highest register down, POP loads from the lowest up.
  always_comb begin
    push_idx = 4'd0;
    pop_idx  = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (list_q[i]) push_idx = 4'(i);
    end
    for (int i = 8; i >= 0; i--) begin
      if (list_q[i]) pop_idx = 4'(i);
    end
  end

  assign idle      = (state == S_IDLE);
  assign step      = (state == S_PUSH) || (state == S_POP);
  assign cur_idx   = (state == S_PUSH) ? push_idx : pop_idx;
  assign list_next = list_q & ~(9'd1 << cur_idx);

`ifdef ST_STACK_LIMIT_EN
  // The candidate address is checked before the request goes out, so a faulting step never reaches memory.
  assign limit_hit = (state == S_PUSH) && (dp_data_out < SP_LIMIT);
`else
  assign limit_hit = 1'b0;
`endif

  assign mem_req     = ((state == S_PUSH) && !limit_hit) || (state == S_POP) || (state == S_MEM1);
  assign mem_we      = mem_req && ((state == S_PUSH) || ((state == S_MEM1) && (op_q == OP_STRSP)));
  assign mem_addr    = ((state == S_PUSH) || (state == S_MEM1)) ? dp_data_out : sp_q;
  assign mem_reg_idx = step ? cur_idx : 4'd0;
  assign xfer        = mem_req && mem_ack;

  assign done  = (state == S_EXEC) || (step && xfer && (list_next == 9'd0)) ||
                 ((state == S_MEM1) && mem_ack) || limit_hit;
  assign fault = limit_hit;

  assign instr_ready  = idle;
  assign dp_data_in   = ((state == S_EXEC) && (op_q == OP_MOVSP)) ? {reg_in[31:2], 2'b00} : sp_q;
  assign dp_op_sel    = idle ? OP_NOP : op_q;
  assign dp_immed7    = idle ? 7'd0 : imm7_q;
  assign dp_immed8    = idle ? 8'd0 : imm8_q;
  assign sp           = sp_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

  assign unused_sink = &{1'b0, reg_in[1:0], SP_LIMIT};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      sp_q           <= SP_RESET;
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
      op_q           <= 8'd0;
      list_q         <= 9'd0;
      imm7_q         <= 7'd0;
      imm8_q         <= 8'd0;
    end else begin
      result_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q   <= instr_op;
            list_q <= instr_reglist;
            imm7_q <= instr_immed7;
            imm8_q <= instr_immed8;
            if ((instr_op == OP_PUSH) && (instr_reglist != 9'd0))
              state <= S_PUSH;
            else if ((instr_op == OP_POP) && (instr_reglist != 9'd0))
              state <= S_POP;
            else if ((instr_op == OP_LDRSP) || (instr_op == OP_STRSP))
              state <= S_MEM1;
            else
              state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_ADDSP, OP_SUBSP: sp_q <= dp_data_out;
            OP_MOVSP:           sp_q <= {reg_in[31:2], 2'b00};
            OP_ADDS: begin
              result_q       <= dp_data_out;
              result_valid_q <= 1'b1;
            end
            default: ;
          endcase
          state <= S_IDLE;
        end
        S_PUSH, S_POP: begin
          if (limit_hit) begin
            list_q <= 9'd0;
            state  <= S_IDLE;
          end else if (xfer) begin
            sp_q   <= dp_data_out;
            list_q <= list_next;
            if (list_next == 9'd0) state <= S_IDLE;
          end
        end
        S_MEM1: begin
          if (mem_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
